// File: rtl/pixel_group_arbiter_if.sv
// Event bus between a pixel_group_arbiter and whatever consumes its events.
//
// Signals:
//   gnt        one-hot grant, packed [ROWS-1:0][COLS-1:0]
//   evt_valid  an event is being presented
//   evt_ready  consumer accepts the event this cycle
//   x_add      row index of the presented event
//   y_add      column index of the presented event
//   pol        polarity field of the presented event
//
// Modports: master = arbiter side, slave = consumer side.
interface pixel_group_arbiter_if #(
  parameter int ROWS    = 4,
  parameter int COLS    = 4,
  parameter int ROW_ADD = 2,
  parameter int COL_ADD = 2,
  parameter int POL_W   = 2
);
  logic [ROWS-1:0][COLS-1:0] gnt;
  logic                      evt_valid;
  logic                      evt_ready;
  logic [ROW_ADD-1:0]        x_add;
  logic [COL_ADD-1:0]        y_add;
  logic [POL_W-1:0]          pol;

  modport master (
    output gnt,
    output evt_valid,
    output x_add,
    output y_add,
    output pol,
    input  evt_ready
  );

  modport slave (
    input  gnt,
    input  evt_valid,
    input  x_add,
    input  y_add,
    input  pol,
    output evt_ready
  );
endinterface

// File: rtl/pixel_group_arbiter.sv
// Row/column arbiter over a ROWS x COLS grid of polarity-tagged pixel
// requests. Each scan snapshots the request grid and serves every
// snapshotted pixel exactly once over a valid/ready event bus, choosing
// rows and then columns either round-robin or lowest-index-first.
//
// Ports:
//   clk_i          clock, rising edge
//   reset_i        synchronous active-high reset
//   enable_i       grant from the next level up; permits scanning
//   mode_i         0 = round-robin, 1 = fixed priority (sampled per scan)
//   req_i          packed [ROWS-1:0][COLS-1:0][POL_W-1:0] pixel requests
//   evt_if         event bus (master): gnt, evt_valid, evt_ready, x/y, pol
//   active_o       arbiter is not idle
//   req_o          OR of all request bits, for the next level up
//   grp_release_o  one-cycle pulse when a scan completes
//   evt_cnt_o      handshakes completed in the current/most recent scan
module pixel_group_arbiter #(
  parameter int ROWS    = 4,
  parameter int COLS    = 4,
  parameter int ROW_ADD = 2,
  parameter int COL_ADD = 2,
  parameter int POL_W   = 2,
  parameter int CNT_W   = 8
) (
  input  logic                                  clk_i,
  input  logic                                  reset_i,
  input  logic                                  enable_i,
  input  logic                                  mode_i,
  input  logic [ROWS-1:0][COLS-1:0][POL_W-1:0]  req_i,
  pixel_group_arbiter_if.master                 evt_if,
  output logic                                  active_o,
  output logic                                  req_o,
  output logic                                  grp_release_o,
  output logic [CNT_W-1:0]                      evt_cnt_o
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ROW_SEL = 3'd1,
    COL_SEL = 3'd2,
    EMIT    = 3'd3,
    RELEASE = 3'd4
  } state_e;

  typedef logic [ROWS-1:0][COLS-1:0][POL_W-1:0] grid_t;

  state_e             state_q,   state_d;
  grid_t              snap_q,    snap_d;
  logic               mode_q,    mode_d;
  logic [ROW_ADD-1:0] row_ptr_q, row_ptr_d;
  logic [COL_ADD-1:0] col_ptr_q, col_ptr_d;
  logic [ROW_ADD-1:0] x_q,       x_d;
  logic [COL_ADD-1:0] y_q,       y_d;
  logic [POL_W-1:0]   pol_q,     pol_d;
  logic [CNT_W-1:0]   cnt_q,     cnt_d;
  // Set when enable_i drops while an event is presented; the event still
  // completes but the scan is abandoned afterwards.
  logic               drop_q,    drop_d;

  logic [ROWS-1:0]    row_has;
  logic [COLS-1:0]    col_has;
  logic [ROW_ADD-1:0] row_sel;
  logic [COL_ADD-1:0] col_sel;
  logic [ROWS-1:0]    row_bit;
  logic [COLS-1:0]    col_bit;
  logic               row_left;
  logic               any_left;
  logic [ROWS-1:0][COLS-1:0] gnt_w;

  assign req_o = |req_i;

  // Occupancy of each snapshot row, and of each column in the current row.
  for (genvar gi = 0; gi < ROWS; gi++) begin : g_row_has
    assign row_has[gi] = |snap_q[gi];
  end
  for (genvar gi = 0; gi < COLS; gi++) begin : g_col_has
    assign col_has[gi] = |snap_q[x_q][gi];
  end

  // What remains once the pixel currently presented is cleared.
  assign row_bit  = ROWS'(1) << x_q;
  assign col_bit  = COLS'(1) << y_q;
  assign row_left = |(col_has & ~col_bit);
  assign any_left = row_left | (|(row_has & ~row_bit));

  // Row choice: round-robin starts one past the last granted row, fixed
  // priority starts at row 0. Only occupied rows can win, so codes beyond
  // ROWS-1 are never produced.
  always_comb begin : row_pick
    int   base;
    int   idx;
    logic found;
    base    = mode_q ? 0 : int'(row_ptr_q) + 1;
    idx     = 0;
    found   = 1'b0;
    row_sel = '0;
    for (int k = 0; k < ROWS; k++) begin
      idx = (base + k) % ROWS;
      if (!found && row_has[idx]) begin
        found   = 1'b1;
        row_sel = ROW_ADD'(idx);
      end
    end
  end

  // Column choice inside the registered row, same rotation rule.
  always_comb begin : col_pick
    int   base;
    int   idx;
    logic found;
    base    = mode_q ? 0 : int'(col_ptr_q) + 1;
    idx     = 0;
    found   = 1'b0;
    col_sel = '0;
    for (int k = 0; k < COLS; k++) begin
      idx = (base + k) % COLS;
      if (!found && col_has[idx]) begin
        found   = 1'b1;
        col_sel = COL_ADD'(idx);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    snap_d    = snap_q;
    mode_d    = mode_q;
    row_ptr_d = row_ptr_q;
    col_ptr_d = col_ptr_q;
    x_d       = x_q;
    y_d       = y_q;
    pol_d     = pol_q;
    cnt_d     = cnt_q;
    drop_d    = drop_q;
    unique case (state_q)
      IDLE: begin
        if (enable_i && req_o) begin
          snap_d  = req_i;
          mode_d  = mode_i;
          cnt_d   = '0;
          state_d = ROW_SEL;
        end
      end
      ROW_SEL: begin
        if (!enable_i) begin
          snap_d  = '0;
          state_d = IDLE;
        end else begin
          x_d     = row_sel;
          state_d = COL_SEL;
        end
      end
      COL_SEL: begin
        if (!enable_i) begin
          snap_d  = '0;
          state_d = IDLE;
        end else begin
          y_d     = col_sel;
          pol_d   = snap_q[x_q][col_sel];
          drop_d  = 1'b0;
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (!enable_i) drop_d = 1'b1;
        if (evt_if.evt_ready) begin
          snap_d[x_q][y_q] = '0;
          if (!mode_q) begin
            row_ptr_d = x_q;
            col_ptr_d = y_q;
          end
          if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
          if (!enable_i || drop_q) begin
            snap_d  = '0;
            state_d = IDLE;
          end else if (row_left) begin
            state_d = COL_SEL;
          end else if (any_left) begin
            state_d = ROW_SEL;
          end else begin
            state_d = RELEASE;
          end
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      snap_q    <= '0;
      mode_q    <= 1'b0;
      row_ptr_q <= '0;
      col_ptr_q <= '0;
      x_q       <= '0;
      y_q       <= '0;
      pol_q     <= '0;
      cnt_q     <= '0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      snap_q    <= snap_d;
      mode_q    <= mode_d;
      row_ptr_q <= row_ptr_d;
      col_ptr_q <= col_ptr_d;
      x_q       <= x_d;
      y_q       <= y_d;
      pol_q     <= pol_d;
      cnt_q     <= cnt_d;
      drop_q    <= drop_d;
    end
  end

  always_comb begin
    gnt_w = '0;
    if (state_q == EMIT) gnt_w[x_q][y_q] = 1'b1;
  end

  assign evt_if.gnt       = gnt_w;
  assign evt_if.evt_valid = (state_q == EMIT);
  assign evt_if.x_add     = x_q;
  assign evt_if.y_add     = y_q;
  assign evt_if.pol       = pol_q;
  assign active_o         = (state_q != IDLE);
  assign grp_release_o    = (state_q == RELEASE);
  assign evt_cnt_o        = cnt_q;

endmodule

// File: tb/tb_pixel_group_arbiter.sv
// Bench for pixel_group_arbiter: directed scans, a scan-order model that
// predicts every event from the snapshot rules, and a negedge compare
// process that checks each presented event against that model.
module tb_pixel_group_arbiter;
  localparam int ROWS    = 4;
  localparam int COLS    = 4;
  localparam int ROW_ADD = 2;
  localparam int COL_ADD = 2;
  localparam int POL_W   = 2;
  localparam int CNT_W   = 8;

  typedef logic [ROWS-1:0][COLS-1:0][POL_W-1:0] req_t;
  typedef struct {
    int r;
    int c;
    int pol;
  } evt_t;

  logic             clk = 1'b0;
  logic             reset_i;
  logic             enable_i;
  logic             mode_i;
  req_t             req_i;
  logic             active_o;
  logic             req_o;
  logic             grp_release_o;
  logic [CNT_W-1:0] evt_cnt_o;

  pixel_group_arbiter_if #(
    .ROWS(ROWS), .COLS(COLS), .ROW_ADD(ROW_ADD), .COL_ADD(COL_ADD), .POL_W(POL_W)
  ) evt_if ();

  pixel_group_arbiter #(
    .ROWS(ROWS), .COLS(COLS), .ROW_ADD(ROW_ADD), .COL_ADD(COL_ADD),
    .POL_W(POL_W), .CNT_W(CNT_W)
  ) dut (
    .clk_i         (clk),
    .reset_i       (reset_i),
    .enable_i      (enable_i),
    .mode_i        (mode_i),
    .req_i         (req_i),
    .evt_if        (evt_if.master),
    .active_o      (active_o),
    .req_o         (req_o),
    .grp_release_o (grp_release_o),
    .evt_cnt_o     (evt_cnt_o)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  int   rel_cnt  = 0;
  int   exp_cnt  = 0;
  int   m_rp     = 0;
  int   m_cp     = 0;
  evt_t exp_q[$];
  evt_t obs_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, want);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Expected event order of one full scan, straight from the arbitration
  // rules: stay in the current row while it has pixels, otherwise pick the
  // next occupied row; round-robin searches start one past the last grant.
  task automatic build_scan(input req_t snap, input logic fixed_mode);
    int   pix[ROWS][COLS];
    int   left;
    int   cur;
    int   start;
    int   cand;
    int   col;
    bit   busy;
    evt_t e;
    left = 0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        pix[r][c] = int'(snap[r][c]);
        if (pix[r][c] != 0) left++;
      end
    cur     = -1;
    exp_cnt = 0;
    while (left > 0) begin
      busy = 1'b0;
      if (cur >= 0)
        for (int c = 0; c < COLS; c++) if (pix[cur][c] != 0) busy = 1'b1;
      if (!busy) begin
        start = fixed_mode ? 0 : m_rp + 1;
        cur   = -1;
        for (int k = 0; k < ROWS; k++) begin
          cand = (start + k) % ROWS;
          if (cur < 0)
            for (int c = 0; c < COLS; c++) if (pix[cand][c] != 0) cur = cand;
        end
      end
      start = fixed_mode ? 0 : m_cp + 1;
      col   = -1;
      for (int k = 0; k < COLS; k++) begin
        cand = (start + k) % COLS;
        if (col < 0 && pix[cur][cand] != 0) col = cand;
      end
      e.r   = cur;
      e.c   = col;
      e.pol = pix[cur][col];
      exp_q.push_back(e);
      pix[cur][col] = 0;
      left--;
      if (!fixed_mode) begin
        m_rp = cur;
        m_cp = col;
      end
    end
  endtask

  // Called with the DUT idle: the next rising edge samples the request.
  task automatic start_scan(input req_t r, input logic m);
    req_i    = r;
    mode_i   = m;
    enable_i = 1'b1;
    build_scan(r, m);
    cyc = 0;
    step();
    req_i = '0;
  endtask

  task automatic wait_release(output int at);
    bit seen;
    seen = 1'b0;
    at   = -1;
    for (int i = 0; i < 200 && !seen; i++) begin
      step();
      if (grp_release_o) begin
        seen = 1'b1;
        at   = cyc;
      end
    end
    check("release_seen", 32'(seen), 32'd1);
    step();
    check("release_one_cycle", 32'(grp_release_o), 32'd0);
    check("idle_after_release", 32'(active_o), 32'd0);
  endtask

  // Compare process: every presented event against the model.
  always @(negedge clk) begin
    logic [ROWS*COLS-1:0] g;
    evt_t e;
    evt_t o;
    if (!reset_i) begin
      if (grp_release_o) rel_cnt++;
      if (evt_if.evt_valid) begin
        check("evt_pending", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q[0];
          g = '0;
          g[e.r*COLS+e.c] = 1'b1;
          check("evt_x",   32'(evt_if.x_add), 32'(e.r));
          check("evt_y",   32'(evt_if.y_add), 32'(e.c));
          check("evt_pol", 32'(evt_if.pol),   32'(e.pol));
          check("evt_gnt", 32'(evt_if.gnt),   32'(g));
          check("evt_cnt", 32'(evt_cnt_o),    32'(exp_cnt));
          if (evt_if.evt_ready) begin
            o.r   = int'(evt_if.x_add);
            o.c   = int'(evt_if.y_add);
            o.pol = int'(evt_if.pol);
            obs_q.push_back(o);
            $display("evt t=%0t x=%0d y=%0d pol=%0d cnt=%0d", $time, o.r, o.c, o.pol, evt_cnt_o);
            void'(exp_q.pop_front());
            exp_cnt++;
          end
        end
      end else begin
        check("idle_gnt", 32'(evt_if.gnt), 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    req_t r;
    int   at;
    int   rel0;

    reset_i            = 1'b1;
    enable_i           = 1'b0;
    mode_i             = 1'b0;
    req_i              = '0;
    evt_if.evt_ready   = 1'b0;
    repeat (3) step();
    reset_i = 1'b0;
    check("rst_valid",   32'(evt_if.evt_valid), 32'd0);
    check("rst_gnt",     32'(evt_if.gnt),       32'd0);
    check("rst_active",  32'(active_o),         32'd0);
    check("rst_release", 32'(grp_release_o),    32'd0);
    check("rst_cnt",     32'(evt_cnt_o),        32'd0);

    // Reset while an event waits for ready, then a clean restart.
    r = '0; r[1][3] = 2'b01;
    start_scan(r, 1'b1);
    step(); step();
    check("t1_valid", 32'(evt_if.evt_valid), 32'd1);
    step(); step();
    reset_i = 1'b1;
    exp_q.delete();
    m_rp = 0; m_cp = 0;
    step();
    check("t1_rst_valid",  32'(evt_if.evt_valid), 32'd0);
    check("t1_rst_gnt",    32'(evt_if.gnt),       32'd0);
    check("t1_rst_x",      32'(evt_if.x_add),     32'd0);
    check("t1_rst_y",      32'(evt_if.y_add),     32'd0);
    check("t1_rst_pol",    32'(evt_if.pol),       32'd0);
    check("t1_rst_active", 32'(active_o),         32'd0);
    reset_i = 1'b0;
    start_scan(r, 1'b1);
    step();
    check("t1_restart_c2", 32'(evt_if.evt_valid), 32'd0);
    step();
    check("t1_restart_c3", 32'(evt_if.evt_valid), 32'd1);
    check("t1_restart_x",  32'(evt_if.x_add),     32'd1);
    check("t1_restart_y",  32'(evt_if.y_add),     32'd3);
    evt_if.evt_ready = 1'b1;
    wait_release(at);

    // Single pixel (2,1) with polarity 2'b10.
    r = '0; r[2][1] = 2'b10;
    start_scan(r, 1'b0);
    step();
    check("t2_c2_valid", 32'(evt_if.evt_valid), 32'd0);
    step();
    check("t2_c3_valid", 32'(evt_if.evt_valid), 32'd1);
    check("t2_x",        32'(evt_if.x_add),     32'd2);
    check("t2_y",        32'(evt_if.y_add),     32'd1);
    check("t2_pol",      32'(evt_if.pol),       32'd2);
    check("t2_gnt",      32'(evt_if.gnt),       32'h0200);
    wait_release(at);
    check("t2_release_cycle", 32'(at),        32'd4);
    check("t2_cnt",           32'(evt_cnt_o), 32'd1);

    // Fixed priority, full grid.
    r = '0;
    for (int i = 0; i < ROWS; i++)
      for (int j = 0; j < COLS; j++) r[i][j] = POL_W'((i + j) % 3 + 1);
    obs_q.delete();
    rel0 = rel_cnt;
    start_scan(r, 1'b1);
    check("t3_model_len",   32'(exp_q.size()),                 32'd16);
    check("t3_model_5",     32'(exp_q[5].r * 4 + exp_q[5].c),  32'd5);
    check("t3_model_5_pol", 32'(exp_q[5].pol),                 32'd3);
    wait_release(at);
    check("t3_release_cycle", 32'(at),                              32'd37);
    check("t3_cnt",           32'(evt_cnt_o),                       32'd16);
    check("t3_one_release",   32'(rel_cnt - rel0),                  32'd1);
    check("t3_obs_len",       32'(obs_q.size()),                    32'd16);
    check("t3_obs_last",      32'(obs_q[15].r * 4 + obs_q[15].c),   32'd15);

    // Round-robin over two scans, pointers starting at zero.
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    m_rp = 0; m_cp = 0;
    r = '0; r[0][0] = 2'b01; r[0][2] = 2'b10; r[1][1] = 2'b11;
    start_scan(r, 1'b0);
    wait_release(at);
    obs_q.delete();
    start_scan(r, 1'b0);
    check("t4_model_0", 32'(exp_q[0].r * 4 + exp_q[0].c), 32'd5);
    check("t4_model_1", 32'(exp_q[1].r * 4 + exp_q[1].c), 32'd2);
    check("t4_model_2", 32'(exp_q[2].r * 4 + exp_q[2].c), 32'd0);
    wait_release(at);
    check("t4_obs_len", 32'(obs_q.size()),                  32'd3);
    check("t4_obs_0",   32'(obs_q[0].r * 4 + obs_q[0].c),   32'd5);
    check("t4_obs_1",   32'(obs_q[1].r * 4 + obs_q[1].c),   32'd2);
    check("t4_obs_2",   32'(obs_q[2].r * 4 + obs_q[2].c),   32'd0);

    // Backpressure, and a request that appears mid-scan.
    obs_q.delete();
    evt_if.evt_ready = 1'b0;
    r = '0; r[0][1] = 2'b01; r[2][2] = 2'b11;
    start_scan(r, 1'b1);
    step(); step();
    r = '0; r[3][3] = 2'b01;
    req_i = r;
    for (int i = 0; i < 5; i++) begin
      step();
      check("t5_hold_valid", 32'(evt_if.evt_valid), 32'd1);
      check("t5_hold_x",     32'(evt_if.x_add),     32'd0);
      check("t5_hold_y",     32'(evt_if.y_add),     32'd1);
      check("t5_hold_pol",   32'(evt_if.pol),       32'd1);
      check("t5_hold_gnt",   32'(evt_if.gnt),       32'h0002);
    end
    evt_if.evt_ready = 1'b1;
    wait_release(at);
    check("t5_scan1_len", 32'(obs_q.size()), 32'd2);
    start_scan(r, 1'b1);
    wait_release(at);
    check("t5_obs_len", 32'(obs_q.size()),                  32'd3);
    check("t5_obs_1",   32'(obs_q[1].r * 4 + obs_q[1].c),   32'd10);
    check("t5_obs_2",   32'(obs_q[2].r * 4 + obs_q[2].c),   32'd15);

    // enable_i dropped in COL_SEL.
    rel0 = rel_cnt;
    r = '0; r[1][2] = 2'b01;
    start_scan(r, 1'b1);
    step();
    check("t6_colsel_active", 32'(active_o), 32'd1);
    enable_i = 1'b0;
    step();
    check("t6_idle",  32'(active_o),          32'd0);
    check("t6_valid", 32'(evt_if.evt_valid),  32'd0);
    step();
    check("t6_no_release", 32'(rel_cnt - rel0), 32'd0);
    exp_q.delete();

    // enable_i dropped while an event waits for ready.
    evt_if.evt_ready = 1'b0;
    obs_q.delete();
    r = '0; r[0][0] = 2'b01; r[0][3] = 2'b10;
    start_scan(r, 1'b1);
    step(); step();
    enable_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t7_hold_valid", 32'(evt_if.evt_valid), 32'd1);
      check("t7_hold_y",     32'(evt_if.y_add),     32'd0);
    end
    evt_if.evt_ready = 1'b1;
    step();
    check("t7_valid",   32'(evt_if.evt_valid), 32'd0);
    check("t7_active",  32'(active_o),         32'd0);
    check("t7_release", 32'(grp_release_o),    32'd0);
    check("t7_cnt",     32'(evt_cnt_o),        32'd1);
    check("t7_obs_len", 32'(obs_q.size()),     32'd1);
    exp_q.delete();
    step();
    check("t7_stay_idle", 32'(active_o), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/pixel_group_arbiter.md
Name: pixel_group_arbiter

Overview:
- Parametrised successor to the lower-level pixel arbiter: row/column arbitration over a ROWS x COLS grid of polarity-tagged pixel requests.
- Captures a request snapshot per scan and serves each snapshotted pixel exactly once.
- Emits address and polarity through a valid/ready event handshake, with selectable round-robin or fixed-priority policy.
- Sits at level 0 of the hierarchy; req_o and grp_release_o feed the next level up.

Parameters:
- ROWS, 4, number of pixel rows (>=2)
- COLS, 4, number of pixel columns (>=2)
- ROW_ADD, 2, row address width, >= clog2(ROWS)
- COL_ADD, 2, column address width, >= clog2(COLS)
- POL_W, 2, polarity bits per pixel; pixel requesting iff its field is nonzero
- CNT_W, 8, width of per-scan event counter

Ports:
- clk_i  in  1  clock, all logic on rising edge
- reset_i  in  1  synchronous active-high reset
- enable_i  in  1  grant from higher level; permits scanning
- mode_i  in  1  0 = round-robin, 1 = fixed priority (lowest index first)
- req_i  in  ROWS*COLS*POL_W  packed [ROWS-1:0][COLS-1:0][POL_W-1:0] pixel requests with polarity
- gnt_o  out  ROWS*COLS  one-hot grant to the pixel currently being emitted
- evt_valid_o  out  1  event valid
- evt_ready_i  in  1  event accepted by downstream
- x_add_o  out  ROW_ADD  row index of current event
- y_add_o  out  COL_ADD  column index of current event
- pol_o  out  POL_W  polarity field of current event (from snapshot)
- active_o  out  1  state != IDLE
- req_o  out  1  combinational OR of all req_i bits
- grp_release_o  out  1  one-cycle pulse when a scan completes
- evt_cnt_o  out  CNT_W  handshakes completed in current or most recent scan

Behaviour:
- Reset (synchronous, reset_i high at posedge):
  - State IDLE; snapshot, pointers and evt_cnt_o = 0.
  - gnt_o, evt_valid_o, x_add_o, y_add_o, pol_o, active_o, grp_release_o = 0.
  - Reset overrides any in-flight handshake.
- States: IDLE, ROW_SEL, COL_SEL, EMIT, RELEASE.
- IDLE:
  - If enable_i && req_o: latch req_i into snapshot, latch mode_i (held for the whole scan), clear evt_cnt_o, go ROW_SEL.
  - Otherwise remain IDLE.
- ROW_SEL: register x_add_o = selected row among rows with any nonzero snapshot field; go COL_SEL.
  - RR: search starts at row_ptr+1, wraps modulo ROWS.
  - Fixed: lowest index.
- COL_SEL: register y_add_o = selected column within row x_add_o, register pol_o from snapshot; go EMIT.
  - RR: search starts at col_ptr+1, wraps modulo COLS.
  - Fixed: lowest index.
- EMIT:
  - evt_valid_o = 1; gnt_o[x_add_o][y_add_o] = 1, all other bits 0.
  - x_add_o, y_add_o and pol_o are held stable until evt_ready_i.
  - On handshake: clear that snapshot field, update row_ptr/col_ptr to the granted indices (RR only), increment evt_cnt_o (saturates at 2^CNT_W-1).
  - Next state after handshake: COL_SEL if the row still has bits; else ROW_SEL if any snapshot bit remains; else RELEASE.
- RELEASE: grp_release_o = 1 for exactly one cycle; go IDLE.
- Latency:
  - Request sampled in IDLE at cycle 0 gives evt_valid_o at cycle 3.
  - Next event in the same row: 2 cycles after handshake. Next event in a new row: 3 cycles.
  - Max throughput is one event per 2 cycles.
- Requests arriving or changing after snapshot are ignored until the next scan. Pixels dropping their request mid-scan are still served from the snapshot.
- enable_i low:
  - In ROW_SEL or COL_SEL: go IDLE next cycle, discard snapshot, no grp_release_o.
  - In EMIT: valid is held until the handshake completes, then go IDLE (no release).
  - In RELEASE: the pulse still completes.
- Handshake and enable_i low in the same cycle count as a completed event.
- Pointers persist across scans; fixed mode does not modify them.
- Unused address codes (ROWS not a power of 2) are never produced.

Test Plan:
- Reset mid-EMIT (evt_valid_o=1, evt_ready_i=0): next cycle all outputs 0, state IDLE; re-request restarts cleanly with first valid 3 cycles later.
- Single pixel (2,1), pol=2'b10, enable_i=1, evt_ready_i=1:
  - evt_valid_o at cycle 3 with x=2, y=1, pol=2'b10, gnt_o bit [2][1] only.
  - grp_release_o pulses at cycle 4; evt_cnt_o=1.
- Fixed mode, all 16 pixels requesting, ready=1: events in order (0,0),(0,1)…(3,3); evt_cnt_o=16; exactly one grp_release_o pulse.
- RR mode, two scans with pixels (0,0),(0,2),(1,1) and row_ptr=0, col_ptr=0 after scan 1: scan 2 order is (1,1),(0,2),(0,0).
- Backpressure: evt_ready_i low 5 cycles during EMIT → evt_valid_o, x, y, pol, gnt_o unchanged; pixel (3,3) asserted mid-scan is not served until the next scan.
- enable_i dropped in COL_SEL → IDLE next cycle, no release pulse.
- enable_i dropped during EMIT with ready=0 → valid held until ready, then IDLE.
